// File: rtl/nibble_packer_if.sv
// ============================================================================
// nibble_packer_if : nibble input stream, flush and packed-word output bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface nibble_packer_if #(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 16
);
  logic [3:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [4*NIBBLES-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_W-1:0]     word_count;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, word_count
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, word_count
  );
endinterface

`default_nettype wire

// File: rtl/nibble_packer.sv
// ============================================================================
// nibble_packer : packs NIBBLES nibbles (LS first) into one word, 1-entry out buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_packer #(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 16
) (
  input  wire                    clk,
  input  wire                    resetn,
  nibble_packer_if.slave         bus
);
  localparam int            W    = 4 * NIBBLES;
  localparam int            CW   = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] FULL = CW'(NIBBLES);

  logic [W-1:0]     acc;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     data_buf;
  logic             buf_valid;
  logic [CNT_W-1:0] words;

  logic             accept;
  logic             free;
  logic             xfer;
  logic             consume;
  logic [CW-1:0]    cnt_acc;

  assign bus.in_ready   = (cnt != FULL);
  assign bus.out_data   = data_buf;
  assign bus.out_valid  = buf_valid;
  assign bus.word_count = words;

  assign accept  = bus.in_valid && bus.in_ready;
  assign free    = !buf_valid || bus.out_ready;
  assign xfer    = (cnt == FULL) && free;
  assign consume = buf_valid && bus.out_ready;
  // Fill level including a nibble taken on this edge, so flush sees it too
  assign cnt_acc = accept ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      cnt       <= '0;
      data_buf  <= '0;
      buf_valid <= 1'b0;
      words     <= '0;
    end else begin
      if (consume) words <= words + 1'b1;

      if (xfer) begin
        data_buf  <= acc;
        buf_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        if (consume) buf_valid <= 1'b0;
        for (int i = 0; i < NIBBLES; i++) begin
          if (accept && cnt == CW'(i)) acc[4*i +: 4] <= bus.in_data;
        end
        if (bus.flush && cnt_acc != '0) cnt <= FULL;
        else                            cnt <= cnt_acc;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_nibble_packer.sv
// ============================================================================
// tb_nibble_packer : directed stimulus with queue scoreboard on output handshake
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nibble_packer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] exp_q[$];

  nibble_packer_if #(.NIBBLES(4), .CNT_W(16)) bus ();

  nibble_packer #(.NIBBLES(4), .CNT_W(16)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected word
  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got %h expected none", bus.out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          bad++;
          $display("FAIL word: got %h expected %h", bus.out_data, e);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] d, input logic fl);
    int waited;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.flush    = fl;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      cycle();
      waited++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'd1, 32'd0);
    cycle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    exp_q.delete();
    cycle();
    resetn = 1'b1;
    cycle();
  endtask

  initial begin
    bus.in_data   = 4'h0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // 1. Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, bus.out_data}, 32'h0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_word_count", {16'd0, bus.word_count}, 32'd0);
    resetn = 1'b1;
    cycle();

    // 2. Basic pack and latency
    bus.out_ready = 1'b1;
    exp_q.push_back(16'h4321);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    chk("lat_e0_valid", {31'd0, bus.out_valid}, 32'd0);
    cycle();
    chk("lat_e1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_e1_data", {16'd0, bus.out_data}, 32'h4321);
    cycle();
    chk("lat_e2_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("basic_wc", {16'd0, bus.word_count}, 32'd1);

    // Asynchronous reset mid-cycle with a buffered word
    bus.out_ready = 1'b0;
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    cycle();
    chk("pre_async_data", {16'd0, bus.out_data}, 32'h8765);
    #3;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_out_data", {16'd0, bus.out_data}, 32'h0);
    chk("async_wc", {16'd0, bus.word_count}, 32'd0);
    chk("async_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cycle();
    resetn = 1'b1;
    cycle();

    // 3. Backpressure
    for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
    chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_out_data", {16'd0, bus.out_data}, 32'h3210);
    bus.in_data  = 4'hF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      cycle();
    end
    bus.in_valid = 1'b0;
    exp_q.push_back(16'h3210);
    exp_q.push_back(16'h7654);
    bus.out_ready = 1'b1;
    cycle();
    chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_data", {16'd0, bus.out_data}, 32'h7654);
    cycle();
    chk("b2b_drain", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_wc", {16'd0, bus.word_count}, 32'd2);

    // 4. Flush partial, then an ignored flush
    exp_q.push_back(16'h00BA);
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    do_flush();
    repeat (3) cycle();
    do_flush();
    repeat (4) cycle();
    chk("flush_wc", {16'd0, bus.word_count}, 32'd3);

    // 5. Flush together with the last nibble
    exp_q.push_back(16'h00C1);
    send(4'h1, 1'b0);
    send(4'hC, 1'b1);
    repeat (3) cycle();
    chk("flush_data_wc", {16'd0, bus.word_count}, 32'd4);

    // 6. Reset mid-word discards partial nibbles
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    pulse_reset();
    exp_q.push_back(16'hBA98);
    send(4'h8, 1'b0);
    send(4'h9, 1'b0);
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    repeat (4) cycle();
    chk("mid_rst_wc", {16'd0, bus.word_count}, 32'd1);
    chk("mid_rst_data", {16'd0, bus.out_data}, 32'hBA98);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
